// File: rtl/toggle_seq_gen.sv
// Four-bit toggle sequencer: toggles a, b, c, d in turn after programmable
// delays, repeating for ROUNDS rounds (or until stop when ROUNDS is 0).
module toggle_seq_gen #(
  parameter int unsigned DLY_A  = 20,
  parameter int unsigned DLY_B  = 30,
  parameter int unsigned DLY_C  = 40,
  parameter int unsigned DLY_D  = 50,
  parameter int unsigned ROUNDS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic [7:0] round_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_A = 3'd1,
    S_WAIT_B = 3'd2,
    S_WAIT_C = 3'd3,
    S_WAIT_D = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [7:0] LD_A     = 8'(DLY_A - 1);
  localparam logic [7:0] LD_B     = 8'(DLY_B - 1);
  localparam logic [7:0] LD_C     = 8'(DLY_C - 1);
  localparam logic [7:0] LD_D     = 8'(DLY_D - 1);
  localparam logic [7:0] ROUNDS_V = 8'(ROUNDS);
  localparam bit         ROUNDS_EN = (ROUNDS != 0);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] round_nxt, round_inc;
  logic       a_nxt, b_nxt, c_nxt, d_nxt;
  logic       busy_nxt, done_nxt;

  assign round_inc = round_cnt + 8'd1;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      d         <= 1'b0;
      round_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      c         <= c_nxt;
      d         <= d_nxt;
      round_cnt <= round_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Stop is checked before the counter in every WAIT state so it beats a
  // coincident toggle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a;
    b_nxt     = b;
    c_nxt     = c;
    d_nxt     = d;
    round_nxt = round_cnt;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_nxt = S_WAIT_A;
          cnt_nxt   = LD_A;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          c_nxt     = 1'b0;
          d_nxt     = 1'b0;
          round_nxt = '0;
        end
      end
      S_WAIT_A: begin
        if (stop) state_nxt = S_IDLE;
        else if (cnt == 8'd0) begin
          a_nxt     = ~a;
          state_nxt = S_WAIT_B;
          cnt_nxt   = LD_B;
        end else cnt_nxt = cnt - 8'd1;
      end
      S_WAIT_B: begin
        if (stop) state_nxt = S_IDLE;
        else if (cnt == 8'd0) begin
          b_nxt     = ~b;
          state_nxt = S_WAIT_C;
          cnt_nxt   = LD_C;
        end else cnt_nxt = cnt - 8'd1;
      end
      S_WAIT_C: begin
        if (stop) state_nxt = S_IDLE;
        else if (cnt == 8'd0) begin
          c_nxt     = ~c;
          state_nxt = S_WAIT_D;
          cnt_nxt   = LD_D;
        end else cnt_nxt = cnt - 8'd1;
      end
      S_WAIT_D: begin
        if (stop) state_nxt = S_IDLE;
        else if (cnt == 8'd0) begin
          d_nxt     = ~d;
          round_nxt = round_inc;
          if (ROUNDS_EN && (round_inc == ROUNDS_V)) begin
            state_nxt = S_DONE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_WAIT_A;
            cnt_nxt   = LD_A;
          end
        end else cnt_nxt = cnt - 8'd1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt == S_WAIT_A) || (state_nxt == S_WAIT_B) ||
               (state_nxt == S_WAIT_C) || (state_nxt == S_WAIT_D);
  end

endmodule

// File: tb/tb_toggle_seq_gen.sv
// Directed bench for toggle_seq_gen: default timing, short-delay run,
// free-running wrap, stop and reset behaviour.
module tb_toggle_seq_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // d0: defaults, d1: all delays 1 / 2 rounds, d2: all delays 1 / endless
  logic       d0_start = 1'b0, d0_stop = 1'b0, d0_busy, d0_done;
  logic [3:0] d0_v;
  logic [7:0] d0_rc;
  logic [2:0] d0_st;
  logic       d1_start = 1'b0, d1_stop = 1'b0, d1_busy, d1_done;
  logic [3:0] d1_v;
  logic [7:0] d1_rc;
  logic [2:0] d1_st;
  logic       d2_start = 1'b0, d2_stop = 1'b0, d2_busy, d2_done;
  logic [3:0] d2_v;
  logic [7:0] d2_rc;
  logic [2:0] d2_st;

  toggle_seq_gen u_d0 (
    .clk(clk), .rst(rst), .start(d0_start), .stop(d0_stop),
    .a(d0_v[3]), .b(d0_v[2]), .c(d0_v[1]), .d(d0_v[0]),
    .busy(d0_busy), .done(d0_done), .round_cnt(d0_rc), .state_dbg(d0_st)
  );

  toggle_seq_gen #(.DLY_A(1), .DLY_B(1), .DLY_C(1), .DLY_D(1), .ROUNDS(2)) u_d1 (
    .clk(clk), .rst(rst), .start(d1_start), .stop(d1_stop),
    .a(d1_v[3]), .b(d1_v[2]), .c(d1_v[1]), .d(d1_v[0]),
    .busy(d1_busy), .done(d1_done), .round_cnt(d1_rc), .state_dbg(d1_st)
  );

  toggle_seq_gen #(.DLY_A(1), .DLY_B(1), .DLY_C(1), .DLY_D(1), .ROUNDS(0)) u_d2 (
    .clk(clk), .rst(rst), .start(d2_start), .stop(d2_stop),
    .a(d2_v[3]), .b(d2_v[2]), .c(d2_v[1]), .d(d2_v[0]),
    .busy(d2_busy), .done(d2_done), .round_cnt(d2_rc), .state_dbg(d2_st)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         t_first[4];
    int         toggles, max_chg, done_cnt, done_t, n;
    logic [3:0] prev, chg;
    logic [7:0] rc140;
    logic       busy979, busy981;
    logic [3:0] fast_exp[10];

    // reset
    step(); step();
    chk("rst_d0_v", 32'(d0_v), 0);
    chk("rst_d0_rc", 32'(d0_rc), 0);
    chk("rst_d0_busy", 32'(d0_busy), 0);
    chk("rst_d0_done", 32'(d0_done), 0);
    chk("rst_d0_st", 32'(d0_st), 0);
    chk("rst_d1_v", 32'(d1_v), 0);
    rst = 1'b0;
    step(); step();
    chk("post_rst_idle", 32'(d0_st), 0);

    // default full run
    d0_start = 1'b1; step(); d0_start = 1'b0;
    chk("d0_t0_busy", 32'(d0_busy), 1);
    chk("d0_t0_v", 32'(d0_v), 0);
    for (int i = 0; i < 4; i++) t_first[i] = -1;
    toggles = 0; max_chg = 0; done_cnt = 0; done_t = -1;
    rc140 = '0; busy979 = 1'b0; busy981 = 1'b1;
    prev = d0_v;
    for (int k = 1; k <= 990; k++) begin
      step();
      chg = d0_v ^ prev;
      n = $countones(chg);
      toggles += n;
      if (n > max_chg) max_chg = n;
      for (int i = 0; i < 4; i++)
        if (chg[3-i] && t_first[i] < 0) t_first[i] = k;
      if (k == 140) rc140 = d0_rc;
      if (k == 979) busy979 = d0_busy;
      if (k == 981) busy981 = d0_busy;
      if (d0_done) begin done_cnt++; done_t = k; end
      prev = d0_v;
    end
    chk("d0_t_a", 32'(t_first[0]), 20);
    chk("d0_t_b", 32'(t_first[1]), 50);
    chk("d0_t_c", 32'(t_first[2]), 90);
    chk("d0_t_d", 32'(t_first[3]), 140);
    chk("d0_rc140", 32'(rc140), 1);
    chk("d0_toggles", 32'(toggles), 28);
    chk("d0_one_chg", 32'(max_chg), 1);
    chk("d0_done_cnt", 32'(done_cnt), 1);
    chk("d0_done_t", 32'(done_t), 981);
    chk("d0_busy979", 32'(busy979), 1);
    chk("d0_busy981", 32'(busy981), 0);
    chk("d0_final_v", 32'(d0_v), 4'b1111);
    chk("d0_final_rc", 32'(d0_rc), 7);
    chk("d0_final_st", 32'(d0_st), 0);

    // stop on the b-toggle edge
    d0_start = 1'b1; step(); d0_start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 49; k++) begin
      step();
      if (d0_done) done_cnt++;
    end
    d0_stop = 1'b1; step(); d0_stop = 1'b0;
    if (d0_done) done_cnt++;
    chk("stop_v", 32'(d0_v), 4'b1000);
    chk("stop_st", 32'(d0_st), 0);
    chk("stop_busy", 32'(d0_busy), 0);
    step(); step();
    if (d0_done) done_cnt++;
    chk("stop_no_done", 32'(done_cnt), 0);
    chk("stop_hold_v", 32'(d0_v), 4'b1000);

    // restart, then reset in WAIT_C
    d0_start = 1'b1; step(); d0_start = 1'b0;
    chk("restart_v", 32'(d0_v), 0);
    chk("restart_rc", 32'(d0_rc), 0);
    t_first[0] = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (d0_v[3] && t_first[0] < 0) t_first[0] = k;
    end
    chk("restart_t_a", 32'(t_first[0]), 20);
    chk("pre_rst_v", 32'(d0_v), 4'b1100);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_v", 32'(d0_v), 0);
    chk("midrst_st", 32'(d0_st), 0);
    chk("midrst_busy", 32'(d0_busy), 0);
    chk("midrst_rc", 32'(d0_rc), 0);
    step(); step();
    chk("midrst_idle", 32'(d0_st), 0);
    d0_start = 1'b1; step(); d0_start = 1'b0;
    t_first[0] = -1; t_first[1] = -1;
    for (int k = 1; k <= 52; k++) begin
      if (k == 3) d0_start = 1'b1;
      if (k == 4) d0_start = 1'b0;
      step();
      if (d0_v[3] && t_first[0] < 0) t_first[0] = k;
      if (d0_v[2] && t_first[1] < 0) t_first[1] = k;
    end
    chk("clean_t_a", 32'(t_first[0]), 20);
    chk("clean_t_b", 32'(t_first[1]), 50);
    d0_stop = 1'b1; step(); d0_stop = 1'b0;

    // start+stop together in IDLE
    d1_start = 1'b1; d1_stop = 1'b1; step(); d1_start = 1'b0; d1_stop = 1'b0;
    chk("startstop_st", 32'(d1_st), 0);
    chk("startstop_busy", 32'(d1_busy), 0);

    // all-ones delays, two rounds; start while busy is ignored
    fast_exp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111,
                 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    d1_start = 1'b1; step(); d1_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) d1_start = 1'b1;
      step();
      d1_start = 1'b0;
      chk($sformatf("fast_v_%0d", k), 32'(d1_v), 32'(fast_exp[k-1]));
      chk($sformatf("fast_done_%0d", k), 32'(d1_done), (k == 9) ? 1 : 0);
      chk($sformatf("fast_busy_%0d", k), 32'(d1_busy), (k <= 7) ? 1 : 0);
      if (k == 8) chk("fast_rc", 32'(d1_rc), 2);
    end

    // endless run wraps round_cnt; stop ends it
    d2_start = 1'b1; step(); d2_start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 1025; k++) begin
      step();
      if (d2_done) done_cnt++;
      if (k == 1020) chk("free_rc255", 32'(d2_rc), 255);
      if (k == 1024) chk("free_rc_wrap", 32'(d2_rc), 0);
    end
    chk("free_v1025", 32'(d2_v), 4'b1000);
    d2_stop = 1'b1; step(); d2_stop = 1'b0;
    chk("free_stop_v", 32'(d2_v), 4'b1000);
    chk("free_stop_st", 32'(d2_st), 0);
    chk("free_stop_busy", 32'(d2_busy), 0);
    chk("free_stop_rc", 32'(d2_rc), 0);
    step();
    if (d2_done) done_cnt++;
    chk("free_no_done", 32'(done_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/toggle_seq_gen.md
TOGGLE_SEQ_GEN -- requirements
Module: toggle_seq_gen

Interface
REQ-001 Parameter DLY_A, default 20: cycles from run start (or previous d toggle) to the a toggle; legal range 1..255.
REQ-002 Parameter DLY_B, default 30: cycles from the a toggle to the b toggle; legal range 1..255.
REQ-003 Parameter DLY_C, default 40: cycles from the b toggle to the c toggle; legal range 1..255.
REQ-004 Parameter DLY_D, default 50: cycles from the c toggle to the d toggle; legal range 1..255.
REQ-005 Parameter ROUNDS, default 7: complete a-b-c-d rounds per run; 0 = run until stop; legal range 0..255.
REQ-006 clk  input  1  sole clock; all logic on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle run request; sampled only in IDLE.
REQ-009 stop  input  1  abort request; sampled in every state.
REQ-010 a, b, c, d  output  1 each  registered stimulus bits that drive the downstream 4-input AND stage.
REQ-011 busy  output  1  high in WAIT_A, WAIT_B, WAIT_C and WAIT_D.
REQ-012 done  output  1  one-cycle pulse on run completion.
REQ-013 round_cnt  output  8  completed rounds in the current run.

Function
REQ-014 States: IDLE, WAIT_A, WAIT_B, WAIT_C, WAIT_D, DONE.
REQ-015 Delays are counted by one 8-bit down-counter that is loaded with DLY_x-1 on entry to WAIT_x and decremented each cycle.
REQ-016 IDLE with start=1 and stop=0 at edge T0 -> WAIT_A, a=b=c=d=0, round_cnt=0.
REQ-017 WAIT_A with counter==0 -> a inverts and state goes to WAIT_B, so the first a toggle lands at edge T0+DLY_A.
REQ-018 WAIT_B, WAIT_C and WAIT_D behave the same way, toggling b, c and d respectively; b toggles at T0+DLY_A+DLY_B, and so on.
REQ-019 One round period is DLY_A+DLY_B+DLY_C+DLY_D cycles (default 140).
REQ-020 At each d toggle, round_cnt increments by 1; round_cnt wraps 255->0 when ROUNDS=0.
REQ-021 On the d toggle, if ROUNDS!=0 and the incremented round_cnt equals ROUNDS -> DONE; otherwise -> WAIT_A with the counter reloaded.
REQ-022 DONE asserts done for exactly one cycle, then -> IDLE; a..d and round_cnt hold.
REQ-023 stop=1 in any WAIT state -> IDLE on the next edge with no toggle on that edge (stop wins over a coincident toggle); done is not asserted and a..d and round_cnt hold.
REQ-024 start while busy or in DONE is ignored.
REQ-025 start and stop together in IDLE -> stays IDLE.
REQ-026 Every output is a direct register output, so no combinational path exists from any input to any output.
REQ-027 At most one of a..d changes on any given edge.

Reset
REQ-028 rst=1 at an edge -> state=IDLE, a=b=c=d=0, busy=0, done=0, round_cnt=0, counter=0, regardless of current state.
REQ-029 rst has priority over start and stop.
REQ-030 After reset deasserts, the block stays IDLE until start.

Verification
REQ-031 Defaults, start at T0 -> a toggles at T0+20, b at T0+50, c at T0+90, d at T0+140; round_cnt=1 at T0+140.
REQ-032 Defaults, full run -> 28 total toggles, round_cnt=7, done pulses at T0+981 for one cycle, busy low from T0+981, a=b=c=d=1.
REQ-033 stop asserted on the edge at T0+50 -> b does not toggle, a=1, b=c=d=0, state IDLE, done never asserted; a new start restarts from 0000.
REQ-034 rst pulsed mid-WAIT_C -> next edge gives all outputs 0 and IDLE; start pulses in the following 5 cycles without rst produce a clean run from T0.
REQ-035 DLY_A=DLY_B=DLY_C=DLY_D=1, ROUNDS=2 -> a, b, c, d toggle on consecutive edges T0+1..T0+8; done at T0+9; a start pulse while busy causes no restart.
REQ-036 ROUNDS=0, DLY_x=1 -> runs past 256 rounds, round_cnt wraps to 0 at round 256, done never asserts, stop ends the run.
